ibex_acc_x_responder: RTL and testbench

Accelerator-side endpoint of the X offload interface: accepts instructions from the core's offload dispatcher, decodes a fixed custom-0 instruction set, executes it (single-cycle or iterative), and returns results on the response channel. Sits in the accelerator subsystem, directly facing the core's `acc_x_*` ports. It is the reference responder used for integration and verification of core offload.

---
 rtl/ibex_acc_x_responder_if.sv | 71 +++++++
 rtl/ibex_acc_x_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_ibex_acc_x_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_acc_x_responder_if.sv
// ibex_acc_x_responder_if
//
// Bundles the X offload channels between the core's dispatcher and an accelerator responder.
//   q_*  request channel  : core -> accelerator (instruction, operands, operand/rd status),
//                           q_ready back from the accelerator
//   k_*  decision channel : accelerator -> core, combinational from q_instr
//   p_*  response channel : accelerator -> core (data, dual writeback, error),
//                           p_ready back from the core
//
// The master modport is the core side, the slave modport is the accelerator side.

interface ibex_acc_x_responder_if;

    // Request channel
    logic             q_valid;
    logic [31:0]      q_instr;
    logic [31:0]      q_rs1;
    logic [31:0]      q_rs2;
    logic [31:0]      q_rs3;
    logic [2:0]       q_rs_valid;   // bit n covers rs(n+1)
    logic [1:0]       q_rd_clean;   // bit0: rd free, bit1: rd+1 free
    logic             q_ready;

    // Decision channel
    logic             k_accept;
    logic [1:0]       k_writeback;  // bit0: writes rd, bit1: writes rd+1

    // Response channel
    logic             p_valid;
    logic [1:0][31:0] p_data;       // [0] rd data, [1] rd+1 data
    logic             p_dualwb;
    logic             p_error;
    logic             p_ready;

    modport master (
        output q_valid,
        output q_instr,
        output q_rs1,
        output q_rs2,
        output q_rs3,
        output q_rs_valid,
        output q_rd_clean,
        input  q_ready,
        input  k_accept,
        input  k_writeback,
        input  p_valid,
        input  p_data,
        input  p_dualwb,
        input  p_error,
        output p_ready
    );

    modport slave (
        input  q_valid,
        input  q_instr,
        input  q_rs1,
        input  q_rs2,
        input  q_rs3,
        input  q_rs_valid,
        input  q_rd_clean,
        output q_ready,
        output k_accept,
        output k_writeback,
        output p_valid,
        output p_data,
        output p_dualwb,
        output p_error,
        input  p_ready
    );

endinterface

// File: rtl/ibex_acc_x_responder.sv
// ibex_acc_x_responder
//
// Accelerator-side endpoint of the X offload interface. Decodes the custom-0 instruction set
// (ADD3, MULW, POPCNT), executes one instruction at a time and returns the result on the
// response channel.
//
// Parameters:
//   XInterfaceTernaryOps    - ADD3 (needs rs3) is accepted only when set
//   XInterfaceDualWriteback - MULW may write rd and rd+1 only when set
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous, active-high reset; drops any instruction in flight
//   acc_x  - X interface, slave side (request, decision and response channels)
//
// ADD3 and POPCNT finish in the handshake cycle and respond in the next cycle. MULW runs a
// 32-iteration shift-add multiplier and responds 33 cycles after the handshake.

module ibex_acc_x_responder #(
    parameter bit XInterfaceTernaryOps    = 1'b0,
    parameter bit XInterfaceDualWriteback = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ibex_acc_x_responder_if.slave acc_x
);

    localparam logic [6:0] OpcodeCustom0 = 7'b0001011;
    localparam logic [2:0] Funct3Add3    = 3'b000;
    localparam logic [2:0] Funct3Mulw    = 3'b001;
    localparam logic [2:0] Funct3Popcnt  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [31:0] popcount32(input logic [31:0] value);
        logic [31:0] count;
        count = '0;
        for (int i = 0; i < 32; i++) begin
            count = count + {31'b0, value[i]};
        end
        return count;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [63:0]      mul_acc_q, mul_acc_d;
    logic [63:0]      mul_mcand_q, mul_mcand_d;
    logic [31:0]      mul_mplier_q, mul_mplier_d;
    logic             rd_zero_q, rd_zero_d;
    logic             dual_q, dual_d;
    logic [1:0][31:0] p_data_q, p_data_d;
    logic             p_dualwb_q, p_dualwb_d;
    logic             p_error_q, p_error_d;

    // ------------------------------------------------------------------------
    // Decode (purely combinational from the instruction word)
    // ------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        is_custom0;
    logic        is_add3;
    logic        is_mulw;
    logic        is_popcnt;
    logic        accept;
    logic        rd_nonzero;
    logic        dual_wb;
    logic [1:0]  writeback;
    logic [2:0]  rs_required;
    logic        operands_ok;
    logic        rd_clean_ok;
    logic        q_ready;
    logic        handshake;
    logic        unused_instr;

    assign opcode     = acc_x.q_instr[6:0];
    assign rd         = acc_x.q_instr[11:7];
    assign funct3     = acc_x.q_instr[14:12];
    assign unused_instr = ^acc_x.q_instr[31:15];

    assign is_custom0 = (opcode == OpcodeCustom0);
    assign is_add3    = is_custom0 && (funct3 == Funct3Add3) && XInterfaceTernaryOps;
    assign is_mulw    = is_custom0 && (funct3 == Funct3Mulw);
    assign is_popcnt  = is_custom0 && (funct3 == Funct3Popcnt);
    assign accept     = is_add3 || is_mulw || is_popcnt;
    assign rd_nonzero = (rd != 5'd0);

    // rd==0 still executes but never claims a register, so the rd+1 write is suppressed too.
    assign dual_wb    = is_mulw && XInterfaceDualWriteback && !rd[0] && rd_nonzero;
    assign writeback  = {dual_wb, accept && rd_nonzero};

    // Every accepted op needs rs1; MULW and ADD3 need rs2; only ADD3 needs rs3.
    assign rs_required = {is_add3, is_add3 || is_mulw, accept};
    assign operands_ok = &(~rs_required | acc_x.q_rs_valid);
    assign rd_clean_ok = &(~writeback | acc_x.q_rd_clean);

    // Unaccepted instructions are swallowed immediately so the dispatcher never stalls on them.
    assign q_ready   = !rst_i && (state_q == StIdle) &&
                       (!accept || (operands_ok && rd_clean_ok));
    assign handshake = acc_x.q_valid && q_ready;

    // ------------------------------------------------------------------------
    // Single-cycle datapaths
    // ------------------------------------------------------------------------
    logic [33:0] add3_sum;
    logic [31:0] popcnt_res;

    assign add3_sum   = {2'b00, acc_x.q_rs1} + {2'b00, acc_x.q_rs2} + {2'b00, acc_x.q_rs3};
    assign popcnt_res = popcount32(acc_x.q_rs1);

    // One shift-add iteration: add the shifted multiplicand when the current multiplier LSB is set.
    logic [63:0] mul_acc_step;
    assign mul_acc_step = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        rd_zero_d    = rd_zero_q;
        dual_d       = dual_q;
        p_data_d     = p_data_q;
        p_dualwb_d   = p_dualwb_q;
        p_error_d    = p_error_q;

        unique case (state_q)
            StIdle: begin
                if (handshake && is_mulw) begin
                    state_d      = StBusy;
                    cnt_d        = 5'd0;
                    mul_acc_d    = 64'd0;
                    mul_mcand_d  = {32'd0, acc_x.q_rs1};
                    mul_mplier_d = acc_x.q_rs2;
                    rd_zero_d    = !rd_nonzero;
                    dual_d       = dual_wb;
                end else if (handshake && accept) begin
                    // ADD3/POPCNT complete here; the response registers carry the result.
                    state_d     = StResp;
                    p_data_d[0] = !rd_nonzero ? 32'd0 :
                                  (is_add3 ? add3_sum[31:0] : popcnt_res);
                    p_data_d[1] = 32'd0;
                    p_dualwb_d  = 1'b0;
                    p_error_d   = is_add3 && (add3_sum[33:32] != 2'b00);
                end
            end

            StBusy: begin
                mul_acc_d    = mul_acc_step;
                mul_mcand_d  = {mul_mcand_q[62:0], 1'b0};
                mul_mplier_d = {1'b0, mul_mplier_q[31:1]};
                cnt_d        = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // Last iteration: capture the final product straight into the response.
                    state_d     = StResp;
                    cnt_d       = 5'd0;
                    p_data_d[0] = rd_zero_q ? 32'd0 : mul_acc_step[31:0];
                    p_data_d[1] = dual_q ? mul_acc_step[63:32] : 32'd0;
                    p_dualwb_d  = dual_q;
                    p_error_d   = 1'b0;
                end
            end

            StResp: begin
                if (acc_x.p_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= 5'd0;
            mul_acc_q    <= 64'd0;
            mul_mcand_q  <= 64'd0;
            mul_mplier_q <= 32'd0;
            rd_zero_q    <= 1'b0;
            dual_q       <= 1'b0;
            p_data_q     <= '0;
            p_dualwb_q   <= 1'b0;
            p_error_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            rd_zero_q    <= rd_zero_d;
            dual_q       <= dual_d;
            p_data_q     <= p_data_d;
            p_dualwb_q   <= p_dualwb_d;
            p_error_q    <= p_error_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign acc_x.q_ready     = q_ready;
    assign acc_x.k_accept    = accept;
    assign acc_x.k_writeback = writeback;
    assign acc_x.p_valid     = (state_q == StResp);
    assign acc_x.p_data      = p_data_q;
    assign acc_x.p_dualwb    = p_dualwb_q;
    assign acc_x.p_error     = p_error_q;

endmodule

// File: tb/tb_ibex_acc_x_responder.sv
// Bench for ibex_acc_x_responder: a vector table for the main decode/execute paths, a scoreboard
// queue for response contents, and hand-written sequences for stalls, backpressure and reset.

module tb_ibex_acc_x_responder;

    localparam logic [6:0] OpcCustom0 = 7'b0001011;
    localparam logic [6:0] OpcOther   = 7'b0110011;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic        acc;
        logic [1:0]  wb;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dual;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dual;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic v0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    ibex_acc_x_responder_if x ();
    ibex_acc_x_responder_if x0 ();

    // Full-featured responder
    ibex_acc_x_responder #(
        .XInterfaceTernaryOps   (1'b1),
        .XInterfaceDualWriteback(1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .acc_x(x)
    );

    // Minimal responder, sharing the request payload but with its own valid
    ibex_acc_x_responder #(
        .XInterfaceTernaryOps   (1'b0),
        .XInterfaceDualWriteback(1'b0)
    ) dut0 (
        .clk_i(clk),
        .rst_i(rst),
        .acc_x(x0)
    );

    assign x0.q_valid    = v0;
    assign x0.q_instr    = x.q_instr;
    assign x0.q_rs1      = x.q_rs1;
    assign x0.q_rs2      = x.q_rs2;
    assign x0.q_rs3      = x.q_rs3;
    assign x0.q_rs_valid = x.q_rs_valid;
    assign x0.q_rd_clean = x.q_rd_clean;
    assign x0.p_ready    = 1'b1;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'b0, f3, rd, opc};
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] rs3,
                                 input logic acc, input logic [1:0] wb, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic dual, input logic err,
                                 input int lat);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
        v.acc = acc; v.wb = wb; v.d0 = d0; v.d1 = d1; v.dual = dual; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1, input logic dual,
                            input logic err);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.dual = dual; e.err = err;
        sb.push_back(e);
    endtask

    // Entered just after the handshake edge; returns just after the edge that consumes it.
    task automatic wait_resp(input string name, input int exp_lat);
        int lat;
        logic got;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (x.p_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        x.q_instr    = v.instr;
        x.q_rs1      = v.rs1;
        x.q_rs2      = v.rs2;
        x.q_rs3      = v.rs3;
        x.q_rs_valid = 3'b111;
        x.q_rd_clean = 2'b11;
        x.q_valid    = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_accept", idx), 64'(x.k_accept), 64'(v.acc));
        chk($sformatf("v%0d_writeback", idx), 64'(x.k_writeback), 64'(v.wb));
        chk($sformatf("v%0d_q_ready", idx), 64'(x.q_ready), 64'd1);
        if (v.acc) push_exp(v.d0, v.d1, v.dual, v.err);
        @(posedge clk);
        #1;
        x.q_valid = 1'b0;
        if (v.acc) begin
            wait_resp($sformatf("v%0d", idx), v.lat);
        end else begin
            repeat (3) begin
                @(negedge clk);
                chk($sformatf("v%0d_no_response", idx), 64'(x.p_valid), 64'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every consumed response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && x.p_valid && x.p_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got d0=0x%0h expected none", x.p_data[0]);
            end else begin
                e = sb.pop_front();
                chk("resp_d0", 64'(x.p_data[0]), 64'(e.d0));
                if (e.dual) chk("resp_d1", 64'(x.p_data[1]), 64'(e.d1));
                chk("resp_dualwb", 64'(x.p_dualwb), 64'(e.dual));
                chk("resp_error", 64'(x.p_error), 64'(e.err));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prod;
        prod = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);

        vt.push_back(mkv(mk(OpcCustom0, 3'b010, 5'd5), 32'hF0F0_0001, 0, 0,
                         1'b1, 2'b01, 32'd9, 0, 1'b0, 1'b0, 1));
        vt.push_back(mkv(mk(OpcCustom0, 3'b000, 5'd3), 32'hFFFF_FFFF, 32'd2, 32'd0,
                         1'b1, 2'b01, 32'd1, 0, 1'b0, 1'b1, 1));
        vt.push_back(mkv(mk(OpcCustom0, 3'b000, 5'd4), 32'd1, 32'd2, 32'd3,
                         1'b1, 2'b01, 32'd6, 0, 1'b0, 1'b0, 1));
        vt.push_back(mkv(mk(OpcCustom0, 3'b001, 5'd6), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
                         1'b1, 2'b11, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 33));
        vt.push_back(mkv(mk(OpcCustom0, 3'b001, 5'd7), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
                         1'b1, 2'b01, 32'h0000_0001, 0, 1'b0, 1'b0, 33));
        vt.push_back(mkv(mk(OpcCustom0, 3'b001, 5'd8), 32'h1234_5678, 32'h9ABC_DEF0, 0,
                         1'b1, 2'b11, prod[31:0], prod[63:32], 1'b1, 1'b0, 33));
        vt.push_back(mkv(mk(OpcCustom0, 3'b001, 5'd0), 32'd7, 32'd9, 0,
                         1'b1, 2'b00, 32'd0, 0, 1'b0, 1'b0, 33));
        vt.push_back(mkv(mk(OpcCustom0, 3'b010, 5'd0), 32'hFFFF_FFFF, 0, 0,
                         1'b1, 2'b00, 32'd0, 0, 1'b0, 1'b0, 1));
        vt.push_back(mkv(mk(OpcCustom0, 3'b010, 5'd1), 32'd0, 0, 0,
                         1'b1, 2'b01, 32'd0, 0, 1'b0, 1'b0, 1));
        vt.push_back(mkv(mk(OpcCustom0, 3'b000, 5'd0), 32'd1, 32'd2, 32'd3,
                         1'b1, 2'b00, 32'd0, 0, 1'b0, 1'b0, 1));
        vt.push_back(mkv(mk(OpcOther, 3'b000, 5'd3), 32'd1, 32'd2, 32'd3,
                         1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0));
        vt.push_back(mkv(mk(OpcCustom0, 3'b011, 5'd3), 32'd1, 32'd2, 32'd3,
                         1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0));

        // Reset state
        rst          = 1'b1;
        v0           = 1'b0;
        x.q_valid    = 1'b0;
        x.q_instr    = mk(OpcCustom0, 3'b010, 5'd5);
        x.q_rs1      = 32'd0;
        x.q_rs2      = 32'd0;
        x.q_rs3      = 32'd0;
        x.q_rs_valid = 3'b111;
        x.q_rd_clean = 2'b11;
        x.p_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_q_ready", 64'(x.q_ready), 64'd0);
        chk("reset_p_valid", 64'(x.p_valid), 64'd0);
        chk("reset_p_data", 64'(x.p_data), 64'd0);
        chk("reset_p_dualwb", 64'(x.p_dualwb), 64'd0);
        chk("reset_p_error", 64'(x.p_error), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

        // ADD3 on the responder without ternary ops: rejected and consumed, no response.
        x.q_instr    = mk(OpcCustom0, 3'b000, 5'd3);
        x.q_rs1      = 32'hFFFF_FFFF;
        x.q_rs2      = 32'd2;
        x.q_rs3      = 32'd0;
        v0           = 1'b1;
        @(negedge clk);
        chk("tern0_accept", 64'(x0.k_accept), 64'd0);
        chk("tern0_writeback", 64'(x0.k_writeback), 64'd0);
        chk("tern0_q_ready", 64'(x0.q_ready), 64'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("tern0_no_response", 64'(x0.p_valid), 64'd0);
        end
        x.q_instr = mk(OpcCustom0, 3'b001, 5'd6);
        @(negedge clk);
        chk("dual0_mulw_writeback", 64'(x0.k_writeback), 64'd1);
        @(posedge clk);
        #1;

        // Operand stall: rs1 not valid for three cycles.
        x.q_instr    = mk(OpcCustom0, 3'b010, 5'd5);
        x.q_rs1      = 32'h0000_00FF;
        x.q_rs_valid = 3'b000;
        x.q_rd_clean = 2'b11;
        x.q_valid    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_rs_q_ready", 64'(x.q_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        x.q_rs_valid = 3'b001;
        @(negedge clk);
        chk("stall_rs_release_q_ready", 64'(x.q_ready), 64'd1);
        push_exp(32'd8, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        x.q_valid = 1'b0;
        wait_resp("stall_rs", 1);

        // rd not clean blocks; rd+1 status is irrelevant for a single writeback.
        x.q_instr    = mk(OpcCustom0, 3'b010, 5'd0);
        x.q_rs_valid = 3'b111;
        x.q_rd_clean = 2'b00;
        @(negedge clk);
        chk("rd0_ignores_clean_q_ready", 64'(x.q_ready), 64'd1);
        @(posedge clk);
        #1;
        x.q_instr    = mk(OpcCustom0, 3'b010, 5'd5);
        x.q_rs1      = 32'h8000_0001;
        x.q_rd_clean = 2'b10;
        x.q_valid    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall_clean_q_ready", 64'(x.q_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        x.q_rd_clean = 2'b01;
        @(negedge clk);
        chk("stall_clean_release_q_ready", 64'(x.q_ready), 64'd1);
        push_exp(32'd2, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        x.q_valid = 1'b0;
        wait_resp("stall_clean", 1);

        // Backpressure: response held for five cycles, next request blocked meanwhile.
        x.p_ready    = 1'b0;
        x.q_instr    = mk(OpcCustom0, 3'b010, 5'd9);
        x.q_rs1      = 32'hAAAA_AAAA;
        x.q_rd_clean = 2'b11;
        x.q_valid    = 1'b1;
        @(negedge clk);
        push_exp(32'd16, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        x.q_instr = mk(OpcCustom0, 3'b010, 5'd10);
        x.q_rs1   = 32'h0000_0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_p_valid", 64'(x.p_valid), 64'd1);
            chk("bp_p_data", 64'(x.p_data[0]), 64'd16);
            chk("bp_q_ready", 64'(x.q_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        x.p_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_p_valid", 64'(x.p_valid), 64'd1);
        chk("bp_release_q_ready", 64'(x.q_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_after_q_ready", 64'(x.q_ready), 64'd1);
        push_exp(32'd1, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        x.q_valid = 1'b0;
        wait_resp("bp_second", 1);

        // Reset in BUSY cycle 10 drops the MULW.
        x.q_instr = mk(OpcCustom0, 3'b001, 5'd6);
        x.q_rs1   = 32'd3;
        x.q_rs2   = 32'd5;
        x.q_valid = 1'b1;
        @(negedge clk);
        chk("rst_busy_handshake_q_ready", 64'(x.q_ready), 64'd1);
        @(posedge clk);
        #1;
        x.q_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy_q_ready", 64'(x.q_ready), 64'd0);
        chk("rst_busy_p_valid", 64'(x.p_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_idle_q_ready", 64'(x.q_ready), 64'd1);
        for (int c = 0; c < 40; c++) begin
            chk("rst_busy_no_response", 64'(x.p_valid), 64'd0);
            @(negedge clk);
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
